// File: rtl/weight_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : weight_load_sequencer
// Description : Streams CHAIN_DEPTH 32-bit weight words from the weight buffer
//               into the weight-load chain of a mac_quad_noadder column.
//               Each word is shifted in with prepare_weight_o high, and a
//               single set_weight_o pulse then latches every stage.
//
// Parameters  : BUFFER_ADDR_WIDTH - weight buffer address width
//               CHAIN_DEPTH       - quad stages in the chain (2..256)
//
// Ports       : clk, rst                 - clock, async active-high reset
//               start_i, abort_i         - load request / abort active load
//               base_addr_i, bank_sel_i  - sampled together with start_i
//               busy_o, done_o           - status / completion pulse
//               buf_rd_en_o, buf_rd_addr_o, buf_rd_data_i - buffer read port
//               prepare_weight_o         - chain shift enable
//               set_weight_o             - weight latch pulse
//               o_load_weight_data_{a,b,c,d}_{0,1} - bank chain inputs
//
// Build macro : WLS_DOUBLE_BANK_EN - when defined, bank_sel_i steers data to
//               the _1 outputs; otherwise _1 outputs are tied to 0 and loads
//               always target _0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module weight_load_sequencer #(
    parameter int BUFFER_ADDR_WIDTH = 15,
    parameter int CHAIN_DEPTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [BUFFER_ADDR_WIDTH-1:0] base_addr_i,
    input  logic                         bank_sel_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         buf_rd_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0] buf_rd_addr_o,
    input  logic [31:0]                  buf_rd_data_i,
    output logic                         prepare_weight_o,
    output logic                         set_weight_o,
    output logic [7:0]                   o_load_weight_data_a_0,
    output logic [7:0]                   o_load_weight_data_b_0,
    output logic [7:0]                   o_load_weight_data_c_0,
    output logic [7:0]                   o_load_weight_data_d_0,
    output logic [7:0]                   o_load_weight_data_a_1,
    output logic [7:0]                   o_load_weight_data_b_1,
    output logic [7:0]                   o_load_weight_data_c_1,
    output logic [7:0]                   o_load_weight_data_d_1
);

    localparam int c_RCW = $clog2(CHAIN_DEPTH);
    localparam int c_SCW = $clog2(CHAIN_DEPTH + 1);

    localparam logic [c_RCW-1:0] c_RD_LAST    = c_RCW'(CHAIN_DEPTH - 1);
    localparam logic [c_SCW-1:0] c_SHIFT_FULL = c_SCW'(CHAIN_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_SET   = 2'd3;

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;
    logic [BUFFER_ADDR_WIDTH-1:0] r_addr;
    logic [c_RCW-1:0]             r_rd_cnt;
    logic [c_SCW-1:0]             r_shift_cnt;
    logic                         r_rd_vld;   // buf_rd_data_i holds a live word
    logic                         r_pw;
    logic [31:0]                  r_wdata_0;

    logic w_fetch;
    logic w_abort;
    logic w_load;

    assign w_fetch = (r_state == c_FETCH);
    // abort only matters while a load is in flight; in IDLE start wins
    assign w_abort = abort_i && (r_state != c_IDLE);
    // a returning word is only accepted if the load was not just aborted
    assign w_load  = r_rd_vld && !w_abort;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_next_state = c_FETCH;
                end
            end
            c_FETCH: begin
                if (abort_i) begin
                    w_next_state = c_IDLE;
                end else if (r_rd_cnt == c_RD_LAST) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                // shift count reaches D in the cycle the last word is being
                // registered, so SET follows its presentation directly
                if (abort_i) begin
                    w_next_state = c_IDLE;
                end else if (r_shift_cnt == c_SHIFT_FULL) begin
                    w_next_state = c_SET;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o        = (r_state != c_IDLE);
        buf_rd_en_o   = w_fetch;
        buf_rd_addr_o = w_fetch ? r_addr : '0;
        // an abort landing on the SET cycle suppresses the latch pulse
        set_weight_o  = (r_state == c_SET) && !abort_i;
        done_o        = (r_state == c_SET) && !abort_i;
    end

    // ------------------------------------------------------------------
    // Read address / counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_rd_cnt    <= '0;
            r_shift_cnt <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && start_i) begin
                r_addr   <= base_addr_i;
                r_rd_cnt <= '0;
            end else if (w_fetch) begin
                // natural wrap at the top of the buffer
                r_addr   <= r_addr + BUFFER_ADDR_WIDTH'(1);
                r_rd_cnt <= r_rd_cnt + c_RCW'(1);
            end

            if ((r_state == c_IDLE) && start_i) begin
                r_shift_cnt <= '0;
            end else if (w_load) begin
                r_shift_cnt <= r_shift_cnt + c_SCW'(1);
            end

            r_rd_vld <= w_fetch && !w_abort;
        end
    end

    // ------------------------------------------------------------------
    // Weight output registers; zero whenever no word is being presented
    // ------------------------------------------------------------------
`ifdef WLS_DOUBLE_BANK_EN
    logic        r_bank;
    logic [31:0] r_wdata_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank    <= 1'b0;
            r_pw      <= 1'b0;
            r_wdata_0 <= '0;
            r_wdata_1 <= '0;
        end else begin
            if ((r_state == c_IDLE) && start_i) begin
                r_bank <= bank_sel_i;
            end
            r_pw      <= w_load;
            r_wdata_0 <= (w_load && !r_bank) ? buf_rd_data_i : 32'h0;
            r_wdata_1 <= (w_load &&  r_bank) ? buf_rd_data_i : 32'h0;
        end
    end

    assign o_load_weight_data_a_1 = r_wdata_1[7:0];
    assign o_load_weight_data_b_1 = r_wdata_1[15:8];
    assign o_load_weight_data_c_1 = r_wdata_1[23:16];
    assign o_load_weight_data_d_1 = r_wdata_1[31:24];
`else
    // bank select has no meaning with a single bank
    logic w_unused_bank_sel;
    assign w_unused_bank_sel = bank_sel_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pw      <= 1'b0;
            r_wdata_0 <= '0;
        end else begin
            r_pw      <= w_load;
            r_wdata_0 <= w_load ? buf_rd_data_i : 32'h0;
        end
    end

    assign o_load_weight_data_a_1 = 8'h00;
    assign o_load_weight_data_b_1 = 8'h00;
    assign o_load_weight_data_c_1 = 8'h00;
    assign o_load_weight_data_d_1 = 8'h00;
`endif

    assign prepare_weight_o       = r_pw;
    assign o_load_weight_data_a_0 = r_wdata_0[7:0];
    assign o_load_weight_data_b_0 = r_wdata_0[15:8];
    assign o_load_weight_data_c_0 = r_wdata_0[23:16];
    assign o_load_weight_data_d_0 = r_wdata_0[31:24];

endmodule
`default_nettype wire

// File: tb/tb_weight_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_load_sequencer
// Description : Directed self-checking bench for weight_load_sequencer with
//               CHAIN_DEPTH=4. Buffer model returns a word one cycle after a
//               read strobe; unstrobed cycles return a poison pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_load_sequencer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [14:0] base_addr_i = '0;
    logic        bank_sel_i = 1'b0;
    logic        busy_o, done_o, buf_rd_en_o;
    logic [14:0] buf_rd_addr_o;
    logic [31:0] buf_rd_data_i = 32'hDEADBEEF;
    logic        prepare_weight_o, set_weight_o;
    logic [7:0]  a0, b0, c0, d0, a1, b1, c1, d1;

    int tests = 0;
    int fails = 0;

    weight_load_sequencer #(
        .BUFFER_ADDR_WIDTH(15),
        .CHAIN_DEPTH      (D)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_i               (start_i),
        .abort_i               (abort_i),
        .base_addr_i           (base_addr_i),
        .bank_sel_i            (bank_sel_i),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .buf_rd_en_o           (buf_rd_en_o),
        .buf_rd_addr_o         (buf_rd_addr_o),
        .buf_rd_data_i         (buf_rd_data_i),
        .prepare_weight_o      (prepare_weight_o),
        .set_weight_o          (set_weight_o),
        .o_load_weight_data_a_0(a0),
        .o_load_weight_data_b_0(b0),
        .o_load_weight_data_c_0(c0),
        .o_load_weight_data_d_0(d0),
        .o_load_weight_data_a_1(a1),
        .o_load_weight_data_b_1(b1),
        .o_load_weight_data_c_1(c1),
        .o_load_weight_data_d_1(d1)
    );

    always #5 clk = ~clk;

    // Buffer contents: address 0x10 holds 0x04030201, 0x11 holds 0x08070605...
    function automatic logic [31:0] word(input logic [14:0] a);
        logic [7:0] b;
        b = {a[5:0], 2'b00} - 8'h3F;
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(posedge clk) begin
        buf_rd_data_i <= buf_rd_en_o ? word(buf_rd_addr_o) : 32'hDEADBEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic eff_bank(input logic bank);
`ifdef WLS_DOUBLE_BANK_EN
        return bank;
`else
        return 1'b0;
`endif
    endfunction

    // One full load from cycle 0 (start sample) to cycle D+4 (back in IDLE).
    // poke2 issues a second, different start at cycle 2 which must be ignored.
    task automatic do_load(input logic [14:0] base, input logic bank, input bit poke2);
        logic [7:0]  a_hand [4];
        logic [14:0] wrap_hand [4];
        logic [31:0] exp_w;
        logic        pw_e;
        a_hand    = '{8'h01, 8'h05, 8'h09, 8'h0D};
        wrap_hand = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
        start_i = 1'b1; base_addr_i = base; bank_sel_i = bank;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= D + 4; c++) begin
            if (poke2 && c == 2) begin
                start_i = 1'b1; base_addr_i = base ^ 15'h1234; bank_sel_i = ~bank;
            end else begin
                start_i = 1'b0;
            end
            pw_e  = (c >= 3) && (c <= D + 2);
            exp_w = pw_e ? word(base + 15'(c - 3)) : 32'h0;
            chk("busy", {31'h0, busy_o}, {31'h0, (c >= 1) && (c <= D + 3)});
            chk("rd_en", {31'h0, buf_rd_en_o}, {31'h0, (c >= 1) && (c <= D)});
            if ((c >= 1) && (c <= D)) begin
                chk("rd_addr", {17'h0, buf_rd_addr_o}, {17'h0, base + 15'(c - 1)});
                if (base == 15'h7FFE)
                    chk("wrap_addr", {17'h0, buf_rd_addr_o}, {17'h0, wrap_hand[c-1]});
            end
            chk("prep_w", {31'h0, prepare_weight_o}, {31'h0, pw_e});
            chk("bank0", {d0, c0, b0, a0}, (eff_bank(bank) == 1'b0) ? exp_w : 32'h0);
            chk("bank1", {d1, c1, b1, a1}, (eff_bank(bank) == 1'b1) ? exp_w : 32'h0);
            if (pw_e && base == 15'h0010) begin
                chk("lane_a_hand", {24'h0, (eff_bank(bank) ? a1 : a0)}, {24'h0, a_hand[c-3]});
            end
            chk("set_w", {31'h0, set_weight_o}, {31'h0, c == D + 3});
            chk("done", {31'h0, done_o}, {31'h0, c == D + 3});
            if (c < D + 4) tick();
        end
        start_i = 1'b0;
    endtask

    initial begin
        // ---- reset state
        #1;
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_rd_en", {31'h0, buf_rd_en_o}, 32'h0);
        chk("rst_set", {31'h0, set_weight_o}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", {31'h0, busy_o}, 32'h0);
        chk("idle_prep", {31'h0, prepare_weight_o}, 32'h0);

        // ---- basic bank-0 load
        do_load(15'h0010, 1'b0, 1'b0);
        // ---- bank-1 load (lands on _0 when single-bank build)
        do_load(15'h0010, 1'b1, 1'b0);
        // ---- address wrap
        do_load(15'h7FFE, 1'b0, 1'b0);

        // ---- start during busy ignored; start at cycle D+4 accepted
        do_load(15'h0020, 1'b0, 1'b1);
        start_i = 1'b1; base_addr_i = 15'h0100; bank_sel_i = 1'b0;
        tick();
        start_i = 1'b0;
        chk("restart_busy", {31'h0, busy_o}, 32'h1);
        chk("restart_addr", {17'h0, buf_rd_addr_o}, 32'h0100);
        for (int i = 0; i < D + 3; i++) tick();
        chk("restart_idle", {31'h0, busy_o}, 32'h0);

        // ---- abort at cycle 5
        start_i = 1'b1; base_addr_i = 15'h0010; bank_sel_i = 1'b0;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        chk("abort_pre_prep", {31'h0, prepare_weight_o}, 32'h1);
        chk("abort_pre_a0", {24'h0, a0}, 32'h09);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy", {31'h0, busy_o}, 32'h0);
        chk("abort_prep", {31'h0, prepare_weight_o}, 32'h0);
        chk("abort_bank0", {d0, c0, b0, a0}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_set", {31'h0, set_weight_o}, 32'h0);
            chk("abort_no_done", {31'h0, done_o}, 32'h0);
            chk("abort_no_prep", {31'h0, prepare_weight_o}, 32'h0);
            tick();
        end

        // ---- abort in IDLE has no effect; start beats simultaneous abort
        abort_i = 1'b1;
        tick();
        chk("idle_abort_busy", {31'h0, busy_o}, 32'h0);
        start_i = 1'b1; base_addr_i = 15'h0040;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_wins_busy", {31'h0, busy_o}, 32'h1);
        chk("start_wins_rd", {31'h0, buf_rd_en_o}, 32'h1);
        for (int i = 0; i < D + 3; i++) tick();
        chk("start_wins_idle", {31'h0, busy_o}, 32'h0);

        // ---- asynchronous reset mid-FETCH (cycle 3)
        start_i = 1'b1; base_addr_i = 15'h0010; bank_sel_i = 1'b0;
        tick();
        start_i = 1'b0;
        tick(); tick();
        chk("mid_rd_en", {31'h0, buf_rd_en_o}, 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'h0, busy_o}, 32'h0);
        chk("arst_rd_en", {31'h0, buf_rd_en_o}, 32'h0);
        chk("arst_addr", {17'h0, buf_rd_addr_o}, 32'h0);
        chk("arst_prep", {31'h0, prepare_weight_o}, 32'h0);
        chk("arst_bank0", {d0, c0, b0, a0}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_rd_en", {31'h0, buf_rd_en_o}, 32'h0);
            chk("post_rst_busy", {31'h0, busy_o}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_load_sequencer.md
# weight_load_sequencer

Drives the weight-load chain of a column of `mac_quad_noadder` stages from the weight buffer. On a start pulse it reads CHAIN_DEPTH 32-bit words (4 lanes × 8 bit) from consecutive buffer addresses and shifts them into the selected weight bank (`_0` or `_1`) of the chain with `prepare_weight` asserted. It then issues a single `set_weight` pulse so every stage latches its weight. It sits between the weight buffer read port and the first quad of each array column.

## Interface
- BUFFER_ADDR_WIDTH, 15, weight buffer address width
- CHAIN_DEPTH, 16, number of quad stages in the chain; also the number of words per load; legal range 2..256
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle load request; sampled only in IDLE
- abort_i  in  1  synchronous abort of an active load
- base_addr_i  in  BUFFER_ADDR_WIDTH  first word address; sampled with start_i
- bank_sel_i  in  1  target bank (0 → `_0` outputs, 1 → `_1` outputs); sampled with start_i
- busy_o  out  1  high from the cycle after start until the set_weight cycle, inclusive
- done_o  out  1  one-cycle completion pulse
- buf_rd_en_o  out  1  buffer read strobe
- buf_rd_addr_o  out  BUFFER_ADDR_WIDTH  buffer read address
- buf_rd_data_i  in  32  read data, valid exactly 1 cycle after buf_rd_en_o; lanes a=[7:0], b=[15:8], c=[23:16], d=[31:24]
- prepare_weight_o  out  1  chain shift enable
- set_weight_o  out  1  one-cycle weight latch pulse
- o_load_weight_data_{a,b,c,d}_0  out  8 each  bank-0 chain inputs
- o_load_weight_data_{a,b,c,d}_1  out  8 each  bank-1 chain inputs

## Operation
- FSM states: IDLE, FETCH, DRAIN, SET.
- IDLE:
  - start_i=1 latches base_addr_i and bank_sel_i, clears the read and shift counters, and moves to FETCH.
- FETCH:
  - buf_rd_en_o=1 for CHAIN_DEPTH consecutive cycles.
  - Address for read k is (base + k) mod 2^BUFFER_ADDR_WIDTH, so the address wraps silently past the top of the buffer.
  - After the last read, moves to DRAIN.
- Data path:
  - Each returning word is registered into the selected bank's output registers.
  - prepare_weight_o is high in the same cycles the registered word is presented.
  - The first word read ends up in the deepest stage; the last word ends up in stage 0.
- DRAIN:
  - Waits until the shift counter reaches CHAIN_DEPTH, then moves to SET.
- SET:
  - set_weight_o=1 and done_o=1 for one cycle, then back to IDLE.
- Outputs that are not being driven are 0:
  - the unselected bank;
  - both banks whenever prepare_weight_o=0.
- start_i while busy is ignored, with no queuing.
- abort_i in FETCH, DRAIN or SET:
  - Next cycle the FSM is in IDLE with all outputs 0.
  - No set_weight_o and no done_o are issued, even if abort_i coincides with the SET cycle.
  - Read data returning after the abort is discarded.
  - abort_i in IDLE has no effect.
  - If start_i and abort_i are both high in IDLE, start wins.
- Reset (any time, including mid-load): FSM returns to IDLE; counters and every output clear to 0 immediately.

## Timing
- The start_i sample cycle is cycle 0. D = CHAIN_DEPTH.
- buf_rd_en_o: cycles 1..D; buf_rd_addr_o = base+k at cycle 1+k.
- buf_rd_data_i valid: cycles 2..D+1.
- prepare_weight_o and weight outputs: cycles 3..D+2 (word k at cycle 3+k).
- set_weight_o and done_o: cycle D+3.
- busy_o: cycles 1..D+3; back in IDLE at D+4. A new start_i is accepted at cycle D+4 at the earliest.
- Throughput: one load per D+4 cycles.
- Reset value of every output: 0.

## Configuration
- WLS_DOUBLE_BANK_EN defined:
  - bank_sel_i selects the `_0` or `_1` outputs as described above.
- WLS_DOUBLE_BANK_EN undefined:
  - bank_sel_i is ignored and loads always target `_0`.
  - All `_1` outputs are constant 0 and their registers are not built.

## Test plan
- Reset/idle: assert rst mid-FETCH at D=4 → all outputs 0 the same cycle; no buf_rd_en_o after release; busy_o=0.
- Basic load, D=4, base=0x0010, bank 0, buffer words 0x04030201..0x10 0F0E0D:
  - reads at 0x10..0x13 in cycles 1..4;
  - a_0 = 0x01, 0x05, 0x09, 0x0D in cycles 3..6 with prepare_weight_o=1;
  - set_weight_o=done_o=1 at cycle 7;
  - all `_1` outputs remain 0.
- Bank 1 with macro defined: same stimulus with bank_sel_i=1 → identical values on `_1` outputs; `_0` outputs stay 0. With the macro undefined → data appears on `_0`.
- Address wrap: base=0x7FFE, D=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Abort: abort_i at cycle 5 of a D=4 load → IDLE at cycle 6; prepare_weight_o=0 from cycle 6; no set_weight_o or done_o ever.
- Start during busy: a second start_i at cycle 2 is ignored; the next start_i at cycle 8 (D=4) is accepted, with busy_o rising at cycle 9.
